mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Request-side controller that sits directly upstream of the 128x8 RAM block and converts single-cycle CPU load/store requests into the RAM's level-held enable/read/write protocol. It latches the request, holds the RAM enable until the RAM raises ready, returns read data and a completion pulse, and then drops enable for one cycle so the RAM's internal ready counter re-arms. A timeout reports an error if ready never arrives, and a wrapping counter records completed accesses.

## Interface
- TIMEOUT_CYCLES, 8: maximum cycles spent in ACCESS waiting for mem_ready before an error completion; legal range 2..255.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only when cpu_busy=0
- cpu_write  in  1  1 = store, 0 = load; sampled with cpu_req
- cpu_addr  in  7  RAM address; sampled with cpu_req
- cpu_wdata  in  8  store data; sampled with cpu_req
- cpu_busy  out  1  high in ACCESS and RECOVER
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_done; 1 = timeout
- cpu_rdata  out  8  load data; held until the next successful load
- access_count  out  8  successful completions, wraps 255->0
- mem_en, mem_read, mem_write  out  1 each  RAM controls
- mem_address  out  7  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; undefined while mem_en=0
- mem_ready  in  1  RAM ready, registered on the RAM side

## Operation
- The block has three states: IDLE, ACCESS, and RECOVER.
- IDLE:
  - mem_en, mem_read, and mem_write are 0.
  - On cpu_req=1, latch cpu_write, cpu_addr, and cpu_wdata into internal registers. Clear the timeout counter and go to ACCESS.
- ACCESS:
  - mem_en=1; mem_read is the inverse of the latched write flag; mem_write is the latched write flag.
  - mem_address and mem_wdata come from the latched registers and stay stable for the whole state.
  - mem_ready=1:
    - Pulse cpu_done=1 with cpu_err=0.
    - For a load, capture mem_rdata into cpu_rdata on this edge.
    - Increment access_count and go to RECOVER.
  - mem_ready=0 with the timeout counter at TIMEOUT_CYCLES-1:
    - Pulse cpu_done=1 with cpu_err=1.
    - cpu_rdata and access_count are unchanged.
    - Go to RECOVER.
  - Otherwise, increment the timeout counter and stay in ACCESS.
  - If mem_ready and the timeout terminal count occur on the same cycle, ready wins and the access succeeds.
- RECOVER:
  - mem_en, mem_read, and mem_write are 0 for exactly one cycle, which re-arms the RAM ready counter.
  - Always go to IDLE.
- cpu_req while cpu_busy=1 is ignored: it is not queued and has no side effect.
- Stores write the RAM on every edge while mem_en is held. Repeated writes of identical data are harmless.
- mem_read and mem_write are never both 1.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0, including mem_address, mem_wdata, cpu_rdata, and access_count.
  - The latched request registers and the timeout counter are 0.
- Reset asserted mid-access: on the next edge the block is in IDLE with mem_en=0. No cpu_done is issued for the aborted request, and cpu_rdata and access_count are cleared.
- Cycle sequence against the RAM, whose ready rises on the second enabled edge:
  - E0: cpu_req sampled in IDLE.
  - E1: RAM sees mem_en=1 and counts.
  - E2: RAM raises mem_ready.
  - E3: controller sees mem_ready, captures data, and cpu_done is high in the following cycle.
  - E4: RECOVER ends; state is IDLE.
  - E5: next cpu_req can be sampled.
- Result: request to cpu_done is 3 edges, and back-to-back throughput is one access per 5 cycles.
- The timeout path asserts cpu_done TIMEOUT_CYCLES edges after entry to ACCESS.
- cpu_done is never high for two consecutive cycles.

## Test plan
- Store then load: write addr 7'h05 data 8'hA5, then read 7'h05 -> cpu_rdata=8'hA5, cpu_err=0, cpu_done 3 edges after each request, access_count=2.
- Timeout: mem_ready tied 0, TIMEOUT_CYCLES=8, read 7'h10 -> cpu_done with cpu_err=1 after 8 ACCESS cycles, mem_en low 1 cycle later, access_count unchanged, cpu_rdata unchanged.
- Busy drop: cpu_req pulsed every cycle for 10 cycles with distinct addresses -> only requests sampled in IDLE (cycle 0 and cycle 5) reach mem_address; exactly 2 cpu_done pulses.
- Reset mid-access: assert reset one cycle after entering ACCESS -> next edge mem_en=0, cpu_busy=0, no cpu_done, all outputs 0; a following read of 7'h05 completes normally.
- Ready/timeout collision: mem_ready model rises exactly on the terminal timeout cycle -> cpu_err=0, data captured, access_count incremented.
- Counter wrap: 256 successful accesses -> access_count returns to 0; a recovery cycle with mem_en=0 appears between every pair of accesses.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// CPU request bus and RAM control bus of the memory request controller.
// slave is the controller's view; master is the view of whatever drives the CPU and RAM sides.
interface mem_ctrl_if;
  logic       cpu_req;
  logic       cpu_write;
  logic [6:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_busy;
  logic       cpu_done;
  logic       cpu_err;
  logic [7:0] cpu_rdata;
  logic [7:0] access_count;

  logic       mem_en;
  logic       mem_read;
  logic       mem_write;
  logic [6:0] mem_address;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_busy, cpu_done, cpu_err, cpu_rdata, access_count,
           mem_en, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_busy, cpu_done, cpu_err, cpu_rdata, access_count,
           mem_en, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Converts single-cycle CPU load/store strobes into the RAM's level-held enable protocol,
// with a ready timeout, a one-cycle recovery gap and a wrapping success counter.
module mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic       clk,
  input logic       reset,
  mem_ctrl_if.slave bus
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRecover
  } state_e;

  state_e     state_q, state_d;
  logic       write_q, write_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tmo_q, tmo_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          write_d = bus.cpu_write;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          tmo_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Ready takes priority over the timeout terminal count.
        if (bus.mem_ready) begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          if (!write_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = StRecover;
        end else if (tmo_q == TmoLast) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StRecover;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Enable is dropped outside ACCESS so the RAM's ready counter re-arms.
  assign bus.mem_en       = (state_q == StAccess);
  assign bus.mem_read     = bus.mem_en & ~write_q;
  assign bus.mem_write    = bus.mem_en & write_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.cpu_busy     = (state_q != StIdle);
  assign bus.cpu_done     = done_q;
  assign bus.cpu_err      = err_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.access_count = count_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a behavioural RAM with programmable ready latency drives the
// memory side, and a transaction-level model predicts completion latency, error and data.
module tb_mem_ctrl;

  localparam int Tmo   = 8;
  localparam int Never = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // RAM environment: ready rises after ram_lat enabled edges, clears whenever enable drops.
  logic [7:0] ram       [128];
  logic [7:0] model_mem [128];
  int         ram_lat;
  int         en_cnt;

  assign bus.mem_rdata = bus.mem_en ? ram[bus.mem_address] : 8'h00;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i]       = 8'($urandom);
      model_mem[i] = ram[i];
    end
    en_cnt        = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
        en_cnt        <= en_cnt + 1;
        bus.mem_ready <= (en_cnt + 1 >= ram_lat);
      end else begin
        en_cnt        <= 0;
        bus.mem_ready <= 1'b0;
      end
    end
  end

  logic [7:0] model_count;
  logic [7:0] model_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the DUT held in reset for two edges and checks cleared outputs.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  bus.cpu_busy, 0);
    check_eq("rst_done",  bus.cpu_done, 0);
    check_eq("rst_err",   bus.cpu_err, 0);
    check_eq("rst_rdata", bus.cpu_rdata, 0);
    check_eq("rst_count", bus.access_count, 0);
    check_eq("rst_memen", {bus.mem_en, bus.mem_read, bus.mem_write}, 0);
    check_eq("rst_addr",  bus.mem_address, 0);
    check_eq("rst_wdata", bus.mem_wdata, 0);
    reset       = 1'b0;
    model_count = 8'h00;
    model_rdata = 8'h00;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic do_access(input bit wr, input logic [6:0] a, input logic [7:0] d);
    int  exp_n;
    bit  exp_err;
    int  n;
    bit  seen;
    exp_err = (ram_lat + 1 > Tmo);
    exp_n   = exp_err ? Tmo : ram_lat + 1;
    check_eq("idle_busy", bus.cpu_busy, 0);
    bus.cpu_req   = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = 7'($urandom);
    bus.cpu_wdata = 8'($urandom);
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k <= 300 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      n = k;
      if (bus.cpu_done) begin
        seen = 1'b1;
      end else begin
        check_eq("acc_en",   bus.mem_en, 1);
        check_eq("acc_rw",   {bus.mem_read, bus.mem_write}, {~wr, wr});
        check_eq("acc_addr", bus.mem_address, a);
        check_eq("acc_wdat", bus.mem_wdata, d);
        check_eq("acc_busy", bus.cpu_busy, 1);
      end
    end
    check_eq("done_seen", seen, 1);
    // RAM is written on every enabled edge, so a timed-out store still lands.
    if (wr) model_mem[a] = d;
    if (!exp_err) begin
      model_count = model_count + 8'd1;
      if (!wr) model_rdata = model_mem[a];
    end
    check_eq("latency", n, exp_n);
    check_eq("err",     bus.cpu_err, exp_err);
    check_eq("rdata",   bus.cpu_rdata, model_rdata);
    check_eq("count",   bus.access_count, model_count);
    check_eq("rec_en",  {bus.mem_en, bus.mem_read, bus.mem_write}, 0);
    @(negedge clk);
    check_eq("done_1cyc", bus.cpu_done, 0);
    check_eq("idle_en",   bus.mem_en, 0);
    check_eq("idle_bsy",  bus.cpu_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       dones;
    int       rises;
    logic     prev_en;
    logic [6:0] addrs [2];
    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    ram_lat       = 2;
    reset         = 1'b1;
    @(negedge clk);
    do_reset();

    // Store then load.
    do_access(1'b1, 7'h05, 8'hA5);
    do_access(1'b0, 7'h05, 8'h3C);
    check_eq("sl_rdata", bus.cpu_rdata, 8'hA5);
    check_eq("sl_count", bus.access_count, 2);

    // Timeout with ready never rising.
    ram_lat = Never;
    do_access(1'b0, 7'h10, 8'h00);
    check_eq("to_rdata", bus.cpu_rdata, 8'hA5);

    // Ready exactly on the terminal timeout cycle, and one cycle too late.
    ram_lat = Tmo - 1;
    do_access(1'b0, 7'h22, 8'h00);
    ram_lat = Tmo;
    do_access(1'b1, 7'h23, 8'h77);

    // Request strobed every cycle: only idle-sampled requests reach the RAM.
    ram_lat = 2;
    dones   = 0;
    rises   = 0;
    prev_en = 1'b0;
    addrs[0] = '0;
    addrs[1] = '0;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 7'(7'h20 + i);
      @(negedge clk);
      if (bus.cpu_done) dones++;
      if (bus.mem_en && !prev_en) begin
        if (rises < 2) addrs[rises] = bus.mem_address;
        rises++;
      end
      prev_en = bus.mem_en;
    end
    bus.cpu_req = 1'b0;
    model_count = model_count + 8'd2;
    model_rdata = model_mem[7'h25];
    check_eq("bd_dones", dones, 2);
    check_eq("bd_rises", rises, 2);
    check_eq("bd_addr0", addrs[0], 7'h20);
    check_eq("bd_addr1", addrs[1], 7'h25);
    check_eq("bd_rdata", bus.cpu_rdata, model_rdata);
    check_eq("bd_count", bus.access_count, model_count);
    check_eq("bd_busy",  bus.cpu_busy, 0);

    // Reset one cycle into ACCESS.
    bus.cpu_req   = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 7'h05;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    check_eq("rma_en",    bus.mem_en, 0);
    check_eq("rma_busy",  bus.cpu_busy, 0);
    check_eq("rma_done",  bus.cpu_done, 0);
    check_eq("rma_rdata", bus.cpu_rdata, 0);
    check_eq("rma_count", bus.access_count, 0);
    check_eq("rma_addr",  bus.mem_address, 0);
    reset       = 1'b0;
    model_count = 8'h00;
    model_rdata = 8'h00;
    @(negedge clk);
    check_eq("rma_nodone", bus.cpu_done, 0);
    do_access(1'b0, 7'h05, 8'h00);
    check_eq("rma_reread", bus.cpu_rdata, 8'hA5);

    // Randomized mix of loads, stores, latencies and timeouts.
    for (int i = 0; i < 60; i++) begin
      ram_lat = ($urandom_range(0, 9) == 0) ? Never : int'($urandom_range(1, 10));
      do_access(1'($urandom), 7'($urandom_range(0, 15)), 8'($urandom));
    end

    // 256 successes from a cleared counter wrap it back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ram_lat = int'($urandom_range(1, Tmo - 1));
      do_access(1'($urandom), 7'($urandom), 8'($urandom));
    end
    check_eq("wrap_count", bus.access_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
